lut_arbiter: RTL and testbench
==============================

Name: lut_arbiter

Overview:
- Shares one synchronous lookup table (1-cycle registered read, ADDR_WIDTH address, DATA_WIDTH data) among N_REQ requesters, e.g. several cipher cores drawing constants from one table.
- Round-robin arbitration with a valid/ready request handshake.
- Tracks the table's read latency and returns each word to the requester that issued it, tagged with a one-hot response valid.
- Sits between the requesting cores and the lookup table instance.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- ADDR_WIDTH, 5, lookup table address width
- DATA_WIDTH, 32, lookup table data width
- ID_WIDTH, $clog2(N_REQ), internal requester index width (derived, not overridden)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  arbitration enable; low blocks new grants, the pipeline still drains
- req_valid  input  N_REQ  per-requester request valid
- req_addr  input  N_REQ*ADDR_WIDTH  packed addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_ready  output  N_REQ  one-hot (or zero) grant; handshake completes when req_valid[i] & req_ready[i]
- lut_addr  output  ADDR_WIDTH  registered address driven to the lookup table
- lut_data  input  DATA_WIDTH  lookup table read data
- rsp_valid  output  N_REQ  one-hot, single-cycle response strobe
- rsp_data  output  DATA_WIDTH  lookup result; valid only while any rsp_valid bit is high
- busy  output  1  high while any accepted request has not yet been returned

Behaviour:
- Reset values: req_ready=0, lut_addr=0, rsp_valid=0, rsp_data=0, busy=0, RR pointer=0, both pipeline stage valids=0.
- req_ready is combinational from req_valid, en, rst and the pointer. It is 0 while rst=1 or en=0.
- At most one grant per cycle. The winner is the first i with req_valid[i]=1, searching from the pointer upward and wrapping N_REQ-1 -> 0.
- On a handshake in cycle t:
  - lut_addr <= req_addr[i]
  - s1_valid <= 1, s1_id <= i
  - pointer <= (i+1) mod N_REQ
  - The pointer is unchanged in cycles with no grant.
- Cycle t+1: the table samples lut_addr. s2_valid <= s1_valid, s2_id <= s1_id.
- Cycle t+2: lut_data holds the word. rsp_valid = s2_valid ? onehot(s2_id) : 0 and rsp_data = lut_data; both are driven combinationally from stage 2 and the table output.
- Latency: the response is exactly 2 cycles after the handshake cycle.
- Throughput: one request per cycle sustained, no bubbles. Responses cannot be back-pressured; requesters must always accept them.
- lut_addr holds its last value when no grant occurs, so no spurious table activity is defined.
- Requester rules (the bench asserts both):
  - Once req_valid[i] is raised it stays high with req_addr stable until granted.
  - A requester may re-request in the cycle after its grant.
- Single requester continuously valid: granted every cycle.
- All requesters continuously valid: grants rotate i, i+1, ... with no starvation. Worst-case wait is N_REQ-1 cycles.
- en falling mid-stream: in-flight stages complete and responses still appear. busy stays high until the last rsp_valid cycle, then falls the next cycle.
- busy = s1_valid | s2_valid.
- Reset mid-operation: stage valids clear, so in-flight responses are dropped and no rsp_valid occurs after reset. The table itself outputs all-ones during reset; rsp_valid=0 masks it.
- Simultaneous grant and response in the same cycle is normal pipelined operation, with no interaction.

Optional Feature:
- Macro LUT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer register is removed.
- Undefined (default): round-robin as above.
- All other timing is identical.

Test Plan:
- Single request: rst 2 cycles, req_valid=0001, addr0=5 at cycle 10 -> req_ready=0001 at cycle 10, lut_addr=5 at cycle 11, rsp_valid=0001 and rsp_data=table[5] at cycle 12, busy high in cycles 11-12.
- All four requesters valid continuously with addrs 1,2,3,4 -> grant order 0,1,2,3,0,...; responses in the same order 2 cycles later with data table[1..4]; no idle cycles.
- en=0 with requests pending -> req_ready=0 and no new lut_addr change; en=1 -> grant resumes at the pointer position. En drop after 2 grants -> both responses still delivered.
- Reset asserted one cycle after a grant -> rsp_valid stays 0 for that request; all outputs at reset values; pointer back to 0.
- Requesters 1 and 3 valid after requester 3 was last granted -> requester 0 absent, so 1 wins; next 3 wins. With LUT_ARB_FIXED_PRIO_EN, 1 wins repeatedly while valid.
- Back-to-back requests from one requester to addrs 0 and 31 (wrap boundary) -> rsp_data table[0] then table[31] on consecutive cycles.

Source files
------------

// File: rtl/lut_arbiter.sv
// Shares one registered-read lookup table among N_REQ requesters with a round-robin
// grant and a two-stage id pipeline. Define LUT_ARB_FIXED_PRIO_EN for fixed priority.
module lut_arbiter #(
    parameter int N_REQ = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    localparam int ID_WIDTH = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
    output logic [N_REQ-1:0]              req_ready,
    output logic [ADDR_WIDTH-1:0]         lut_addr,
    input  logic [DATA_WIDTH-1:0]         lut_data,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy
);

    // Handshake: a request transfers in the cycle req_valid[i] & req_ready[i];
    // req_ready never depends on a requester dropping valid, and responses
    // carry no ready because requesters must always accept them.
    logic                  found;
    logic [ID_WIDTH-1:0]   win_id;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  grant_ok;
    logic                  s1_valid;
    logic                  s2_valid;
    logic [ID_WIDTH-1:0]   s1_id;
    logic [ID_WIDTH-1:0]   s2_id;

`ifdef LUT_ARB_FIXED_PRIO_EN
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                found  = 1'b1;
                win_id = ID_WIDTH'(k);
            end
        end
    end
`else
    logic [ID_WIDTH-1:0] ptr;

    // Search starts at ptr and wraps; the first valid requester wins.
    always_comb begin
        logic [ID_WIDTH:0] cand;
        found  = 1'b0;
        win_id = '0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (ID_WIDTH + 1)'(k);
            if (cand >= (ID_WIDTH + 1)'(N_REQ)) begin
                cand = cand - (ID_WIDTH + 1)'(N_REQ);
            end
            if (!found && req_valid[cand[ID_WIDTH-1:0]]) begin
                found  = 1'b1;
                win_id = cand[ID_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_ok) begin
            ptr <= (win_id == ID_WIDTH'(N_REQ - 1)) ? '0 : win_id + ID_WIDTH'(1);
        end
    end
`endif

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_WIDTH'(i) == win_id) begin
                win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign grant_ok  = found & en & ~rst;
    assign req_ready = grant_ok ? (N_REQ'(1) << win_id) : '0;

    // Stage 1 covers the table's address-sample cycle, stage 2 its data cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lut_addr <= '0;
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_id    <= '0;
        end else begin
            s1_valid <= grant_ok;
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            if (grant_ok) begin
                lut_addr <= win_addr;
                s1_id    <= win_id;
            end
        end
    end

    // The table drives all-ones during reset; gating with s2_valid hides it.
    assign rsp_valid = s2_valid ? (N_REQ'(1) << s2_id) : '0;
    assign rsp_data  = s2_valid ? lut_data : '0;
    assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_lut_arbiter.sv
// Scoreboard bench for lut_arbiter: a table model, directed phases and random traffic,
// with a predictor pushing expected responses and a monitor popping them.
module tb_lut_arbiter;
    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en  = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   lut_addr;
    logic [DW-1:0]   lut_data;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            busy;

    lut_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .lut_addr(lut_addr), .lut_data(lut_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    // ---------------- clock / table model ----------------
    always #5 clk = ~clk;

    logic [DW-1:0] tbl [1<<AW];
    always @(posedge clk) lut_data <= rst ? '1 : tbl[lut_addr];

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    int            id_q[$];
    int            due_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_id = N - 1;
    int            grant_cnt = 0;
    bit            chk_en = 1'b0;
    bit            hs_pend = 1'b0;
    logic [AW-1:0] exp_lut = '0;
    logic [AW-1:0] next_lut = '0;
    logic [N-1:0]  prev_valid = '0;
    logic [N-1:0]  prev_hs = '0;
    logic [N*AW-1:0] prev_addr = '0;
    logic          prev_rst = 1'b1;
    logic [N-1:0]  hs_last = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: actual %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Winner = valid requester closest after the last grant (or lowest index).
    function automatic int exp_winner(input logic [N-1:0] v, input int last);
        int best = -1;
        int bestd = N + 1;
        int d;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
`ifdef LUT_ARB_FIXED_PRIO_EN
                d = i;
`else
                d = (i - last - 1 + 2 * N) % N;
`endif
                if (d < bestd) begin
                    bestd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            id_q.delete();
            due_q.delete();
            last_id = N - 1;
            exp_lut = '0;
        end else if (hs_pend) begin
            exp_lut = next_lut;
        end
        hs_pend = 1'b0;
    end

    // Monitor: compares busy and every response against the queue head.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, exp_q.size() != 0);
            if (due_q.size() != 0 && due_q[0] == cyc) begin
                chk("rsp_valid", rsp_valid, N'(1) << id_q[0]);
                chk("rsp_data", rsp_data, exp_q[0]);
                void'(exp_q.pop_front());
                void'(id_q.pop_front());
                void'(due_q.pop_front());
            end else begin
                chk("rsp_idle", rsp_valid, '0);
            end
        end
    end

    // Predictor: checks grants and lut_addr, pushes expected responses.
    always @(negedge clk) begin : pred
        int w;
        logic [N-1:0] er;
        logic [AW-1:0] a;
        #1;
        if (chk_en) begin
            er = '0;
            w = -1;
            if (!rst && en) w = exp_winner(req_valid, last_id);
            if (w >= 0) er[w] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("lut_addr", lut_addr, exp_lut);
            for (int i = 0; i < N; i++) begin
                if (prev_valid[i] && !prev_hs[i] && !prev_rst && !rst)
                    chk("req_hold", {req_valid[i], req_addr[i*AW +: AW]},
                        {1'b1, prev_addr[i*AW +: AW]});
            end
            if (w >= 0) begin
                a = req_addr[w*AW +: AW];
                exp_q.push_back(tbl[a]);
                id_q.push_back(w);
                due_q.push_back(cyc + 2);
                last_id = w;
                next_lut = a;
                hs_pend = 1'b1;
                grant_cnt++;
            end
            prev_valid = req_valid;
            prev_hs = req_valid & er;
            prev_addr = req_addr;
            prev_rst = rst;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        hs_last = req_valid & req_ready;
        @(posedge clk);
        #1;
    endtask

    // A requester may only change while idle or right after its grant.
    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a);
        if (!req_valid[i] || hs_last[i]) begin
            req_valid[i] = v;
            req_addr[i*AW +: AW] = a;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, '0);
        while ((req_valid != '0 || exp_q.size() != 0) && n < 60) begin
            tick();
            for (int i = 0; i < N; i++) set_req(i, 1'b0, '0);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL drain_timeout @cycle %0d: actual pending expected idle", cyc);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog @cycle %0d: actual running expected finished", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int g0;
        for (int i = 0; i < (1 << AW); i++) tbl[i] = $urandom();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        chk("rst_lut_addr", lut_addr, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, '0);
        rst = 1'b0;
        repeat (6) tick();

        // Single request to address 5.
        set_req(0, 1'b1, 5'd5);
        tick();
        set_req(0, 1'b0, '0);
        repeat (3) tick();

        // All requesters continuously valid: rotation with no idle cycles.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1));
        g0 = grant_cnt;
        repeat (12) begin
            tick();
            for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1));
        end
        chk("no_idle_grants", grant_cnt - g0, 12);
        wait_idle();

        // Enable low while requests pend, then drop after two grants.
        en = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 8));
        repeat (4) tick();
        en = 1'b1;
        repeat (2) begin
            tick();
            for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 8));
        end
        en = 1'b0;
        repeat (4) tick();
        en = 1'b1;
        wait_idle();

        // Reset one cycle after a grant drops the in-flight response.
        set_req(2, 1'b1, 5'd7);
        tick();
        set_req(2, 1'b0, '0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_lut_addr", lut_addr, '0);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 20));
        tick();
        wait_idle();

        // Requester 3 granted last, then 1 and 3 compete.
        set_req(3, 1'b1, 5'd9);
        tick();
        set_req(3, 1'b0, '0);
        tick();
        set_req(1, 1'b1, 5'd10);
        set_req(3, 1'b1, 5'd11);
        repeat (4) begin
            tick();
            set_req(1, 1'b1, 5'd10);
            set_req(3, 1'b1, 5'd11);
        end
        wait_idle();

        // Back-to-back addresses 0 and the top of the table.
        set_req(0, 1'b1, '0);
        tick();
        set_req(0, 1'b1, {AW{1'b1}});
        tick();
        wait_idle();

        // Random traffic with occasional enable drops and resets.
        repeat (400) begin
            for (int i = 0; i < N; i++)
                set_req(i, $urandom_range(0, 99) < 60, AW'($urandom_range(0, (1 << AW) - 1)));
            en = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        en = 1'b1;
        wait_idle();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
